// File: rtl/pla_sop_engine.sv
// Programmable AND/OR (or AND/XOR) plane evaluator.
// Two-stage valid/ready pipeline; term table written only when the pipeline is empty.
module pla_sop_engine #(
  parameter int N_IN   = 8,
  parameter int N_TERM = 16,
  parameter int N_OUT  = 4,
  localparam int IW    = $clog2(N_TERM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [N_IN-1:0]   cfg_mask,
  input  logic [N_IN-1:0]   cfg_val,
  input  logic [N_OUT-1:0]  cfg_out,
  input  logic              cfg_xor,
  output logic              cfg_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_y,
  output logic              busy
);

  logic [N_IN-1:0]   mask_q [N_TERM];
  logic [N_IN-1:0]   val_q  [N_TERM];
  logic [N_OUT-1:0]  out_q  [N_TERM];
  logic              xor_q;

  logic              s1_valid;
  logic [N_TERM-1:0] s1_hit;
  logic              s2_valid;
  logic [N_OUT-1:0]  s2_y;

  logic              s1_adv;
  logic              s2_adv;
  logic              in_fire;
  logic              cfg_fire;
  logic [N_TERM-1:0] hit;
  logic [N_TERM-1:0] col [N_OUT];
  logic [N_OUT-1:0]  y_next;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = rst_n && s1_adv && !cfg_we;
  assign cfg_ready = rst_n && !s1_valid && !s2_valid;
  assign in_fire   = in_valid && in_ready;
  assign cfg_fire  = cfg_we && cfg_ready;
  assign busy      = s1_valid || s2_valid;
  assign out_valid = s2_valid;
  assign out_y     = s2_y;

  // AND-plane: uncared inputs are forced to match.
  always_comb begin
    hit = '0;
    for (int t = 0; t < N_TERM; t++) begin
      hit[t] = &((in_x ~^ val_q[t]) | ~mask_q[t]);
    end
  end

  always_comb begin
    col    = '{default: '0};
    y_next = '0;
    for (int j = 0; j < N_OUT; j++) begin
      for (int t = 0; t < N_TERM; t++) begin
        col[j][t] = out_q[t][j] && s1_hit[t];
      end
      y_next[j] = xor_q ? ^col[j] : |col[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TERM; t++) begin
        mask_q[t] <= '0;
        val_q[t]  <= '0;
        out_q[t]  <= '0;
      end
      xor_q <= 1'b0;
    end else if (cfg_fire) begin
      mask_q[cfg_idx] <= cfg_mask;
      val_q[cfg_idx]  <= cfg_val;
      out_q[cfg_idx]  <= cfg_out;
      xor_q           <= cfg_xor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      s2_valid <= 1'b0;
      s2_y     <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) s1_hit <= hit;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_y <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_pla_sop_engine.sv
// Directed + randomized bench for pla_sop_engine.
// Scoreboard of expected outputs built from a term-counting reference model.
module tb_pla_sop_engine;

  localparam int NI = 8;
  localparam int NT = 16;
  localparam int NO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [3:0]    cfg_idx;
  logic [NI-1:0] cfg_mask;
  logic [NI-1:0] cfg_val;
  logic [NO-1:0] cfg_out;
  logic          cfg_xor;
  logic          cfg_ready;
  logic          in_valid;
  logic          in_ready;
  logic [NI-1:0] in_x;
  logic          out_valid;
  logic          out_ready;
  logic [NO-1:0] out_y;
  logic          busy;

  pla_sop_engine #(.N_IN(NI), .N_TERM(NT), .N_OUT(NO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .cfg_val(cfg_val), .cfg_out(cfg_out), .cfg_xor(cfg_xor),
    .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NI-1:0] m_mask [NT];
  logic [NI-1:0] m_val  [NT];
  logic [NO-1:0] m_out  [NT];
  bit            m_xor;

  logic [NO-1:0] sb [$];
  int            in_acc   = 0;
  bit            cfg_done = 0;
  bit            last_ov  = 0;
  bit            saw_stall = 0;
  bit            dir_use  = 0;
  logic [NO-1:0] dir_exp  = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Count member terms whose cared bits match; OR = any, XOR = odd count.
  function automatic logic [NO-1:0] model(logic [NI-1:0] x);
    logic [NO-1:0] y;
    int cnt;
    y = '0;
    for (int j = 0; j < NO; j++) begin
      cnt = 0;
      for (int t = 0; t < NT; t++)
        if (m_out[t][j] && ((x & m_mask[t]) == (m_val[t] & m_mask[t])))
          cnt++;
      y[j] = m_xor ? (cnt % 2 == 1) : (cnt > 0);
    end
    return y;
  endfunction

  function automatic void clear_model();
    for (int t = 0; t < NT; t++) begin
      m_mask[t] = '0;
      m_val[t]  = '0;
      m_out[t]  = '0;
    end
    m_xor = 0;
  endfunction

  task automatic cycle();
    int occ;
    #1;
    occ = sb.size();
    chk("in_ready", in_ready, !cfg_we && (occ < 2 || out_ready));
    chk("cfg_ready", cfg_ready, occ == 0);
    chk("busy", busy, occ != 0);
    if (occ == 0) chk("idle_valid", out_valid, 0);
    if (!in_ready && in_valid) saw_stall = 1;
    last_ov = out_valid;
    if (out_valid && out_ready && occ != 0)
      chk("out_y", out_y, sb.pop_front());
    if (in_valid && in_ready) begin
      sb.push_back(dir_use ? dir_exp : model(in_x));
      in_acc++;
    end
    if (cfg_we && cfg_ready) begin
      m_mask[cfg_idx] = cfg_mask;
      m_val[cfg_idx]  = cfg_val;
      m_out[cfg_idx]  = cfg_out;
      m_xor           = cfg_xor;
      cfg_done        = 1;
    end
    @(negedge clk);
  endtask

  task automatic cfg(int idx, logic [NI-1:0] mk, logic [NI-1:0] vl,
                     logic [NO-1:0] ot, bit xm);
    cfg_we = 1; cfg_idx = idx[3:0];
    cfg_mask = mk; cfg_val = vl; cfg_out = ot; cfg_xor = xm;
    cfg_done = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (cfg_done) break;
    end
    chk("cfg_timeout", cfg_done, 1);
    cfg_we = 0;
  endtask

  task automatic send(logic [NI-1:0] x, bit use_dir, logic [NO-1:0] e);
    int start;
    start = in_acc;
    in_valid = 1; in_x = x;
    dir_use = use_dir; dir_exp = e;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (in_acc != start) break;
    end
    chk("send_timeout", in_acc - start, 1);
    dir_use = 0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic rand_table(bit xm);
    for (int t = 0; t < NT; t++)
      cfg(t, 8'($urandom & $urandom), 8'($urandom), 4'($urandom), xm);
  endtask

  initial begin
    clear_model();
    rst_n = 0; cfg_we = 0; cfg_idx = '0; cfg_mask = '0; cfg_val = '0;
    cfg_out = '0; cfg_xor = 0; in_valid = 0; in_x = '0; out_ready = 1;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_y", out_y, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // Empty table: every output 0, two-cycle latency.
    send(8'hFF, 1, 4'h0);
    in_valid = 0;
    cycle();
    chk("lat_c1", last_ov, 0);
    cycle();
    chk("lat_c2", last_ov, 1);
    drain();

    cfg(0, 8'h17, 8'h02, 4'h1, 0);
    cfg(1, 8'h48, 8'h48, 4'h1, 0);
    send(8'h02, 1, 4'h1);
    send(8'h03, 1, 4'h0);
    send(8'h48, 1, 4'h1);
    drain();

    cfg(0, 8'h17, 8'h02, 4'h1, 1);
    cfg(1, 8'h40, 8'h00, 4'h1, 1);
    send(8'h02, 1, 4'h0);
    send(8'h42, 1, 4'h1);
    drain();

    // Eight back-to-back vectors with a 3-cycle output stall.
    rand_table(0);
    saw_stall = 0;
    begin
      int cyc;
      int start;
      cyc = 0; start = in_acc;
      while (in_acc - start < 8 && cyc < 60) begin
        out_ready = !(cyc >= 3 && cyc <= 5);
        in_valid = 1; in_x = 8'($urandom);
        cycle();
        cyc++;
      end
      chk("stream8_count", in_acc - start, 8);
    end
    chk("stream8_stall", saw_stall, 1);
    drain();

    for (int r = 0; r < 2; r++) begin
      rand_table(r[0]);
      for (int i = 0; i < 150; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_x      = 8'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
      drain();
    end

    // Write arriving while busy waits; in-flight vectors keep old table.
    cfg(0, 8'h17, 8'h02, 4'h1, 1);
    cfg(1, 8'h40, 8'h00, 4'h1, 1);
    for (int t = 2; t < NT; t++) cfg(t, 8'h00, 8'h00, 4'h0, 1);
    out_ready = 0;
    send(8'h42, 1, 4'h1);
    send(8'h02, 1, 4'h0);
    cfg_we = 1; cfg_idx = 4'd0; cfg_mask = 8'h00; cfg_val = 8'h00;
    cfg_out = 4'h2; cfg_xor = 0; cfg_done = 0;
    in_valid = 1; in_x = 8'h02; dir_use = 1; dir_exp = 4'h3;
    #1;
    chk("coll_in_ready", in_ready, 0);
    chk("coll_cfg_ready", cfg_ready, 0);
    out_ready = 1;
    begin
      int start;
      start = in_acc;
      for (int i = 0; i < 50; i++) begin
        cycle();
        if (cfg_done) cfg_we = 0;
        if (in_acc != start) break;
      end
      chk("coll_accept", in_acc - start, 1);
    end
    dir_use = 0;
    chk("coll_cfg", cfg_done, 1);
    drain();

    // Reset with two vectors in flight.
    out_ready = 0;
    send(8'h02, 1, 4'h3);
    send(8'h02, 1, 4'h3);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 0);
    sb.delete();
    clear_model();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    send(8'h02, 1, 4'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pla_sop_engine.md
PLA_SOP_ENGINE -- requirements
Module: pla_sop_engine

Interface
REQ-001 Parameter N_IN, 8, number of primary inputs (1..32).
REQ-002 Parameter N_TERM, 16, number of programmable product terms (2..64, power of two).
REQ-003 Parameter N_OUT, 4, number of outputs (1..16).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cfg_we  in  1  term-programming write request.
REQ-007 cfg_idx  in  log2(N_TERM)  term index to write.
REQ-008 cfg_mask  in  N_IN  care bits; 1 = input participates in term.
REQ-009 cfg_val  in  N_IN  required literal value for each cared input.
REQ-010 cfg_out  in  N_OUT  OR-plane membership of the term, one bit per output.
REQ-011 cfg_xor  in  1  written with every cfg_we; plane mode, 0 = OR (SOP), 1 = XOR (ESOP).
REQ-012 cfg_ready  out  1  high when a cfg_we is accepted this cycle.
REQ-013 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-014 in_x  in  N_IN  input vector, bit i = x_i.
REQ-015 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-016 out_y  out  N_OUT  evaluated function, bit j = y_j.
REQ-017 busy  out  1  high while any pipeline stage holds valid data.

Function
REQ-018 Term t SHALL be hit iff ((in_x XNOR val[t]) OR NOT mask[t]) is all-ones; mask = 0 gives a constant-1 term.
REQ-019 y_j SHALL be the OR (xor_mode=0) or XOR (xor_mode=1) of hit[t] over all t with out[t][j]=1; no member terms gives y_j = 0.
REQ-020 Pipeline SHALL be two registered stages: S1 captures hit vector, S2 captures out_y; latency 2 cycles from accepted input to out_valid with no stall.
REQ-021 Transfer occurs on valid&ready same cycle; throughput one vector per cycle when out_ready held high.
REQ-022 S2 advance = !s2_valid | out_ready; S1 advance = !s1_valid | S2 advance; in_ready = S1 advance & !cfg_we.
REQ-023 out_valid, out_y SHALL hold stable while out_valid=1 and out_ready=0; no vector dropped or duplicated.
REQ-024 cfg_ready SHALL equal !busy & !in_valid-transfer-pending, i.e. !s1_valid & !s2_valid; cfg_we with cfg_ready=0 is ignored and must be held by the source.
REQ-025 Accepted write updates mask/val/out of term cfg_idx and xor_mode in one cycle; effective for inputs accepted on the next cycle.
REQ-026 Simultaneous cfg_we and in_valid with empty pipeline: configuration wins, in_ready=0 that cycle, input accepted the following cycle.
REQ-027 Term storage SHALL be registers (no RAM) readable combinationally by the AND-plane.
REQ-028 Pipeline valid flags SHALL not depend on out_y contents; X on unused-term fields SHALL not propagate (mask/out reset to 0).

Reset
REQ-029 On rst_n=0: s1_valid, s2_valid, out_valid, busy = 0; out_y = 0; all mask, val, out = 0; xor_mode = 0.
REQ-030 Reset mid-operation SHALL discard in-flight vectors; first out_valid after release only for inputs accepted after release.
REQ-031 in_ready and cfg_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release (pipeline empty).

Verification
REQ-032 After reset, no config, in_x=0xFF accepted -> out_y=0x0 with out_valid two cycles later.
REQ-033 Program term 0 mask=0x17 val=0x02 out=0x1 xor=0, term 1 mask=0x48 val=0x48 out=0x1; in_x=0x02 -> out_y=0x1; in_x=0x03 -> 0x0; in_x=0x48 -> 0x1.
REQ-034 Same terms with xor=1, term 1 also covering 0x02 (mask=0x40 val=0x00); in_x=0x02 -> out_y=0x0 (both hit, XOR cancels); in_x=0x42 -> 0x1.
REQ-035 Stream 8 vectors back-to-back, out_ready low cycles 3-5 -> all 8 results in order, no loss, in_ready low once S1 and S2 full.
REQ-036 cfg_we asserted with in_valid on same cycle and with busy=1 -> write delayed until cfg_ready=1; in-flight results use old table.
REQ-037 rst_n pulsed low with 2 vectors in flight -> out_valid=0 within same cycle, table cleared, next vector in_x=0x02 -> out_y=0x0.
